// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: synchronizes, debounces and edge-detects the coin and drink-select
// switches, then issues spaced one-cycle coin pulses. Optional macro: COIN_TOTAL_EN.
module coin_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       quarter_raw,
    input  logic       diet_raw,
    input  logic       soda_raw,
`ifdef COIN_TOTAL_EN
    input  logic       total_clr,
    output logic [7:0] coin_total,
`endif
    output logic       n_pulse,
    output logic       d_pulse,
    output logic       q_pulse,
    output logic       diet_sel,
    output logic       drop_err
);
    localparam int unsigned NCH     = 5;
    localparam int unsigned NCOIN   = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned CH_DIET = 3;
    localparam int unsigned CH_SODA = 4;
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    logic [NCH-1:0]            raw;
    logic [NCH-1:0]            sync1_q;
    logic [NCH-1:0]            sync2_q;
    logic [NCH-1:0]            deb_q, deb_d;
    logic [NCH-1:0]            strb_q, strb_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCOIN-1:0]          pend_q, pend_d;
    logic [NCOIN-1:0]          pulse_q, pulse_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      drop_q, drop_d;
    logic                      sel_q, sel_d;

    // Channel order: nickel, dime, quarter (coins, priority order), then diet, soda.
    assign raw = {soda_raw, diet_raw, quarter_raw, dime_raw, nickel_raw};

    // Debounce: debounced value follows the synced one only after a run of DEBOUNCE_CYCLES differences.
    always_comb begin
        deb_d  = deb_q;
        strb_d = '0;
        cnt_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] + CNT_W'(1) == DEB_LIM) begin
                    deb_d[i]  = sync2_q[i];
                    strb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Arbiter, pending flags (set beats same-cycle clear) and selection latch.
    always_comb begin
        pulse_d = '0;
        gap_d   = gap_q;
        if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else if (pend_q != '0) begin
            gap_d = GAP_LOAD;
            if (pend_q[0]) begin
                pulse_d[0] = 1'b1;
            end else if (pend_q[1]) begin
                pulse_d[1] = 1'b1;
            end else begin
                pulse_d[2] = 1'b1;
            end
        end
        pend_d = (pend_q & ~pulse_d) | strb_q[NCOIN-1:0];
        drop_d = |(strb_q[NCOIN-1:0] & pend_q & ~pulse_d);
        sel_d  = sel_q;
        if (strb_q[CH_DIET] && !strb_q[CH_SODA]) begin
            sel_d = 1'b1;
        end else if (strb_q[CH_SODA] && !strb_q[CH_DIET]) begin
            sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            pulse_q <= '0;
            gap_q   <= '0;
            drop_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
            sel_q   <= sel_d;
        end
    end

    assign n_pulse  = pulse_q[0];
    assign d_pulse  = pulse_q[1];
    assign q_pulse  = pulse_q[2];
    assign diet_sel = sel_q;
    assign drop_err = drop_q;

`ifdef COIN_TOTAL_EN
    localparam int unsigned TOT_W = 8;

    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W-1:0] add;
    logic [TOT_W:0]   sum;

    // Saturating running total of issued coins; clear wins over a same-cycle add.
    always_comb begin
        add = '0;
        if (pulse_q[0]) begin
            add = TOT_W'(5);
        end else if (pulse_q[1]) begin
            add = TOT_W'(10);
        end else if (pulse_q[2]) begin
            add = TOT_W'(25);
        end
        sum = {1'b0, total_q} + {1'b0, add};
        if (total_clr) begin
            total_d = '0;
        end else if (sum[TOT_W]) begin
            total_d = '1;
        end else begin
            total_d = sum[TOT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: directed scenarios plus random stimulus against an
// event/timestamp reference model; a second instance uses short debounce and a long gap.
`timescale 1ns/1ps
module tb_coin_input_conditioner;
    localparam int D0 = 4;
    localparam int G0 = 2;
    localparam int D1 = 1;
    localparam int G1 = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic nickel_raw = 1'b0;
    logic dime_raw = 1'b0;
    logic quarter_raw = 1'b0;
    logic diet_raw = 1'b0;
    logic soda_raw = 1'b0;
    logic total_clr = 1'b0;
    logic n0, d0, q0, sel0, drop0;
    logic n1, d1, q1, sel1, drop1;
`ifdef COIN_TOTAL_EN
    logic [7:0] tot0, tot1;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    coin_input_conditioner #(.DEBOUNCE_CYCLES(D0), .GAP_CYCLES(G0)) u_dut0 (
        .clk(clk), .reset(reset),
        .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
        .diet_raw(diet_raw), .soda_raw(soda_raw),
`ifdef COIN_TOTAL_EN
        .total_clr(total_clr), .coin_total(tot0),
`endif
        .n_pulse(n0), .d_pulse(d0), .q_pulse(q0), .diet_sel(sel0), .drop_err(drop0)
    );

    coin_input_conditioner #(.DEBOUNCE_CYCLES(D1), .GAP_CYCLES(G1)) u_dut1 (
        .clk(clk), .reset(reset),
        .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
        .diet_raw(diet_raw), .soda_raw(soda_raw),
`ifdef COIN_TOTAL_EN
        .total_clr(total_clr), .coin_total(tot1),
`endif
        .n_pulse(n1), .d_pulse(d1), .q_pulse(q1), .diet_sel(sel1), .drop_err(drop1)
    );

    // Reference model: debounced-rise events become pending coins; issue slots are timestamps.
    bit [4:0] m_r1, m_r2;
    bit [4:0] m_deb [2];
    bit [4:0] m_rise [2];
    int       m_run [2][5];
    bit [2:0] m_pend [2];
    int       m_next_ok [2];
    bit [2:0] e_pulse [2];
    bit       e_drop [2];
    bit       e_sel [2];
    int       e_tot [2];

    task automatic model_edge(input int k, input int dcyc, input int gcyc,
                              input bit [4:0] s, input bit rst, input bit clr);
        bit [2:0] arr;
        bit [4:0] rise;
        bit       found;
        int       add;
        if (rst) begin
            m_deb[k] = '0; m_rise[k] = '0; m_pend[k] = '0; m_next_ok[k] = 0;
            e_pulse[k] = '0; e_drop[k] = 1'b0; e_sel[k] = 1'b0; e_tot[k] = 0;
            for (int c = 0; c < 5; c++) m_run[k][c] = 0;
        end else begin
            add = e_pulse[k][0] ? 5 : e_pulse[k][1] ? 10 : e_pulse[k][2] ? 25 : 0;
            if (clr) e_tot[k] = 0;
            else e_tot[k] = (e_tot[k] + add > 255) ? 255 : e_tot[k] + add;
            e_pulse[k] = '0;
            found = 1'b0;
            if (cyc >= m_next_ok[k]) begin
                for (int c = 0; c < 3; c++) begin
                    if (!found && m_pend[k][c]) begin
                        found = 1'b1;
                        e_pulse[k][c] = 1'b1;
                        m_pend[k][c] = 1'b0;
                        m_next_ok[k] = cyc + gcyc + 1;
                    end
                end
            end
            arr = m_rise[k][2:0];
            e_drop[k] = |(arr & m_pend[k]);
            m_pend[k] = m_pend[k] | arr;
            if (m_rise[k][3] != m_rise[k][4]) e_sel[k] = m_rise[k][3];
            rise = '0;
            for (int c = 0; c < 5; c++) begin
                if (s[c] != m_deb[k][c]) begin
                    m_run[k][c] = m_run[k][c] + 1;
                    if (m_run[k][c] == dcyc) begin
                        m_deb[k][c] = s[c];
                        rise[c] = s[c];
                        m_run[k][c] = 0;
                    end
                end else begin
                    m_run[k][c] = 0;
                end
            end
            m_rise[k] = rise;
        end
    endtask

    task automatic tick();
        bit [4:0] s;
        @(posedge clk);
        s = m_r2;
        model_edge(0, D0, G0, s, reset, total_clr);
        model_edge(1, D1, G1, s, reset, total_clr);
        if (reset) begin
            m_r1 = '0;
            m_r2 = '0;
        end else begin
            m_r2 = m_r1;
            m_r1 = {soda_raw, diet_raw, quarter_raw, dime_raw, nickel_raw};
        end
        cyc++;
        #1;
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [7:0] t;
`ifdef COIN_TOTAL_EN
        t = 8'(e_tot[k]);
`else
        t = 8'h00;
`endif
        return {e_pulse[k], e_drop[k], e_sel[k], t};
    endfunction

    function automatic logic [12:0] obs_vec(input int k);
        logic [7:0] t;
        t = 8'h00;
`ifdef COIN_TOTAL_EN
        t = (k == 0) ? tot0 : tot1;
`endif
        if (k == 0) return {q0, d0, n0, drop0, sel0, t};
        return {q1, d1, n1, drop1, sel1, t};
    endfunction

    task automatic set_raw(input bit [4:0] v);
        {soda_raw, diet_raw, quarter_raw, dime_raw, nickel_raw} = v;
    endtask

    task automatic idle(input int n);
        set_raw(5'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL idle dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_raw(5'($urandom));
        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs_vec(k) !== 13'h0) begin
                fails++;
                $display("FAIL reset_state dut%0d got=%h exp=0", k, obs_vec(k));
            end
        end
        reset = 1'b0;
        idle(15);
        // coins pending when a one-cycle reset hits
        set_raw(5'b00111);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        set_raw(5'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== 13'h0) begin
                    fails++;
                    $display("FAIL reset_pending dut%0d cyc=%0d got=%h exp=0", k, cyc, obs_vec(k));
                end
            end
        end
    endtask

    task automatic test_latency();
        set_raw(5'b00001);
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({n0, d0, q0, drop0} !== {(i == 7), 3'b000}) begin
                fails++;
                $display("FAIL latency edge=%0d got=%b exp=%b", i, {n0, d0, q0, drop0}, {(i == 7), 3'b000});
            end
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL latency_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle(15);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 16; i++) begin
            dime_raw = (i < 3);
            tick();
            tests++;
            if (d0 !== 1'b0) begin
                fails++;
                $display("FAIL glitch edge=%0d got=%b exp=0", i, d0);
            end
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL glitch_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle(15);
    endtask

    task automatic test_contention();
        set_raw(5'b00111);
        for (int i = 0; i < 18; i++) begin
            tick();
            tests++;
            if ({n0, d0, q0} !== {(i == 7), (i == 10), (i == 13)}) begin
                fails++;
                $display("FAIL contention edge=%0d got=%b exp=%b", i, {n0, d0, q0}, {(i == 7), (i == 10), (i == 13)});
            end
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL contention_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle(15);
    endtask

    task automatic test_drop();
        int drops1, qs1, drops0, qs0;
        drops1 = 0; qs1 = 0; drops0 = 0; qs0 = 0;
        for (int i = 0; i < 20; i++) begin
            quarter_raw = (i < 5) && (i % 2 == 0);
            tick();
            drops1 += int'(drop1); qs1 += int'(q1);
            drops0 += int'(drop0); qs0 += int'(q0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL drop_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
        tests++;
        if (drops1 != 1 || qs1 != 2) begin
            fails++;
            $display("FAIL drop_count dut1 drops=%0d q_pulses=%0d exp drops=1 q_pulses=2", drops1, qs1);
        end
        tests++;
        if (drops0 != 0 || qs0 != 0) begin
            fails++;
            $display("FAIL drop_glitch dut0 drops=%0d q_pulses=%0d exp 0 and 0", drops0, qs0);
        end
        idle(15);
    endtask

    task automatic test_select();
        bit [4:0] pats [4];
        bit       want [4];
        pats[0] = 5'b01000; want[0] = 1'b1;
        pats[1] = 5'b10000; want[1] = 1'b0;
        pats[2] = 5'b11000; want[2] = 1'b0;
        pats[3] = 5'b01000; want[3] = 1'b1;
        for (int p = 0; p < 5; p++) begin
            set_raw(p < 4 ? pats[p] : 5'b11000);
            for (int i = 0; i < 16; i++) begin
                if (i == 8) set_raw(5'b0);
                tick();
                for (int k = 0; k < 2; k++) begin
                    tests++;
                    if (obs_vec(k) !== exp_vec(k)) begin
                        fails++;
                        $display("FAIL select_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                    end
                end
            end
            tests++;
            if (sel0 !== (p < 4 ? want[p] : 1'b1)) begin
                fails++;
                $display("FAIL select step=%0d got=%b exp=%b", p, sel0, (p < 4 ? want[p] : 1'b1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) nickel_raw = ~nickel_raw;
            if ($urandom_range(0, 7) == 0) dime_raw = ~dime_raw;
            if ($urandom_range(0, 7) == 0) quarter_raw = ~quarter_raw;
            if ($urandom_range(0, 15) == 0) diet_raw = ~diet_raw;
            if ($urandom_range(0, 15) == 0) soda_raw = ~soda_raw;
            reset = ($urandom_range(0, 199) == 0);
`ifdef COIN_TOTAL_EN
            total_clr = ($urandom_range(0, 59) == 0);
`endif
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    fails++;
                    $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", k, cyc, obs_vec(k), exp_vec(k));
                end
            end
        end
        reset = 1'b0;
        total_clr = 1'b0;
        idle(15);
    endtask

`ifdef COIN_TOTAL_EN
    task automatic test_total();
        bit [4:0] seq [4];
        seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00100; seq[3] = 5'b00100;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            set_raw(seq[p]);
            for (int i = 0; i < 6; i++) tick();
            idle(12);
        end
        tests++;
        if (tot0 !== 8'd65) begin
            fails++;
            $display("FAIL coin_total got=%0d exp=65", tot0);
        end
        total_clr = 1'b1;
        tick();
        total_clr = 1'b0;
        tests++;
        if (tot0 !== 8'd0) begin
            fails++;
            $display("FAIL total_clr got=%0d exp=0", tot0);
        end
        idle(5);
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_contention();
        test_drop();
        test_select();
        test_random();
`ifdef COIN_TOTAL_EN
        test_total();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
